relu_maxpool8: RTL and testbench

- 8-lane 1-D max-pooling stage, directly downstream of the 8-lane ReLU stage in the ECG CNN datapath.
- Consumes the 8-bit post-ReLU lane bytes and their per-lane valid strobes.
- Reduces each lane independently over non-overlapping windows of POOL_K valid samples (stride = POOL_K).
- Emits one pooled byte per window, with a one-cycle valid pulse, towards feature-map write-back.

---
 rtl/relu_maxpool8.sv | 173 +++++++++++++++++
 tb/tb_relu_maxpool8.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool8.sv
`default_nettype none
// ============================================================================
//  Module   : relu_maxpool8
//  Purpose  : 8-lane 1-D max-pooling stage behind the 8-lane ReLU stage.
//             Each lane reduces non-overlapping windows of POOL_K valid
//             samples. It emits one pooled byte per window, together with a
//             one-cycle valid pulse. Lanes are fully independent.
//  Ports    : clk_cal                  datapath clock (rising edge)
//             rst_n                    asynchronous active-low reset
//             Pool_Din1..8             post-ReLU lane bytes (unsigned)
//             Pool_Din_vld1..8         per-lane sample-valid strobes
//             pool_bypass              level: registered pass-through
//             pool_flush               pulse: clear all partial windows
//             Pool_Dout1..8            pooled lane results (registered)
//             Pool_Dout_vld1..8        one-cycle result pulses
//             pool_busy                any lane holds a partial window
//  Options  : `define MAXPOOL_PARTIAL_FLUSH_EN to emit partial windows on
//             pool_flush. Without it, a flush discards them silently.
//  Revision : 1.0  initial release
// ============================================================================
module relu_maxpool8 #(
   parameter int POOL_K = 2,
   parameter int CNT_W  = 3
) (
   input  logic       clk_cal,
   input  logic       rst_n,
   input  logic [7:0] Pool_Din1,
   input  logic [7:0] Pool_Din2,
   input  logic [7:0] Pool_Din3,
   input  logic [7:0] Pool_Din4,
   input  logic [7:0] Pool_Din5,
   input  logic [7:0] Pool_Din6,
   input  logic [7:0] Pool_Din7,
   input  logic [7:0] Pool_Din8,
   input  logic       Pool_Din_vld1,
   input  logic       Pool_Din_vld2,
   input  logic       Pool_Din_vld3,
   input  logic       Pool_Din_vld4,
   input  logic       Pool_Din_vld5,
   input  logic       Pool_Din_vld6,
   input  logic       Pool_Din_vld7,
   input  logic       Pool_Din_vld8,
   input  logic       pool_bypass,
   input  logic       pool_flush,
   output logic [7:0] Pool_Dout1,
   output logic [7:0] Pool_Dout2,
   output logic [7:0] Pool_Dout3,
   output logic [7:0] Pool_Dout4,
   output logic [7:0] Pool_Dout5,
   output logic [7:0] Pool_Dout6,
   output logic [7:0] Pool_Dout7,
   output logic [7:0] Pool_Dout8,
   output logic       Pool_Dout_vld1,
   output logic       Pool_Dout_vld2,
   output logic       Pool_Dout_vld3,
   output logic       Pool_Dout_vld4,
   output logic       Pool_Dout_vld5,
   output logic       Pool_Dout_vld6,
   output logic       Pool_Dout_vld7,
   output logic       Pool_Dout_vld8,
   output logic       pool_busy
);

   localparam logic [CNT_W-1:0] c_last = CNT_W'(POOL_K - 1);

   logic [7:0] w_din [8];
   logic [7:0] w_vld;
   logic [7:0] w_dout [8];
   logic [7:0] w_dout_vld;
   logic [7:0] w_lane_busy;
   logic       r_busy;

   assign w_din[0] = Pool_Din1;
   assign w_din[1] = Pool_Din2;
   assign w_din[2] = Pool_Din3;
   assign w_din[3] = Pool_Din4;
   assign w_din[4] = Pool_Din5;
   assign w_din[5] = Pool_Din6;
   assign w_din[6] = Pool_Din7;
   assign w_din[7] = Pool_Din8;
   assign w_vld = {Pool_Din_vld8, Pool_Din_vld7, Pool_Din_vld6, Pool_Din_vld5,
                   Pool_Din_vld4, Pool_Din_vld3, Pool_Din_vld2, Pool_Din_vld1};

   for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      logic [CNT_W-1:0] r_cnt;
      logic [7:0]       r_acc;
      logic [7:0]       r_dout;
      logic             r_dout_vld;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic [7:0]       w_max;

      // A fresh window seeds from the incoming sample. Ties keep acc.
      assign w_max = (r_cnt == '0)           ? w_din[gi] :
                     (w_din[gi] > r_acc)     ? w_din[gi] : r_acc;

      always_comb begin
         w_cnt_nxt = r_cnt;
         if (pool_bypass || pool_flush) begin
            w_cnt_nxt = '0;
         end else if (w_vld[gi]) begin
            w_cnt_nxt = (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
         end
      end

      assign w_lane_busy[gi] = (w_cnt_nxt != '0);
      assign w_dout[gi]      = r_dout;
      assign w_dout_vld[gi]  = r_dout_vld;

      always_ff @(posedge clk_cal or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
         end else begin
            r_cnt <= w_cnt_nxt;
            if (pool_bypass) begin
               r_dout     <= w_din[gi];
               r_dout_vld <= w_vld[gi];
            end else if (pool_flush) begin
`ifdef MAXPOOL_PARTIAL_FLUSH_EN
               // Emit whatever the window holds, including a same-cycle sample.
               if ((r_cnt != '0) || w_vld[gi]) begin
                  r_dout     <= w_vld[gi] ? w_max : r_acc;
                  r_dout_vld <= 1'b1;
               end else begin
                  r_dout_vld <= 1'b0;
               end
`else
               r_dout_vld <= 1'b0;
`endif
            end else if (w_vld[gi]) begin
               if (r_cnt == c_last) begin
                  r_dout     <= w_max;
                  r_dout_vld <= 1'b1;
               end else begin
                  r_acc      <= w_max;
                  r_dout_vld <= 1'b0;
               end
            end else begin
               r_dout_vld <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_cal or negedge rst_n) begin
      if (!rst_n) r_busy <= 1'b0;
      else        r_busy <= |w_lane_busy;
   end

   assign pool_busy = r_busy;

   assign Pool_Dout1 = w_dout[0];
   assign Pool_Dout2 = w_dout[1];
   assign Pool_Dout3 = w_dout[2];
   assign Pool_Dout4 = w_dout[3];
   assign Pool_Dout5 = w_dout[4];
   assign Pool_Dout6 = w_dout[5];
   assign Pool_Dout7 = w_dout[6];
   assign Pool_Dout8 = w_dout[7];

   assign Pool_Dout_vld1 = w_dout_vld[0];
   assign Pool_Dout_vld2 = w_dout_vld[1];
   assign Pool_Dout_vld3 = w_dout_vld[2];
   assign Pool_Dout_vld4 = w_dout_vld[3];
   assign Pool_Dout_vld5 = w_dout_vld[4];
   assign Pool_Dout_vld6 = w_dout_vld[5];
   assign Pool_Dout_vld7 = w_dout_vld[6];
   assign Pool_Dout_vld8 = w_dout_vld[7];

endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_relu_maxpool8
//  Purpose  : Scoreboard bench for relu_maxpool8 (POOL_K=2). Stimulus pushes
//             the expected byte and the expected cycle for each lane. A
//             monitor pops one expectation per output pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_relu_maxpool8;

   typedef struct {
      int val;
      int cyc;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] din [8];
   logic [7:0] dvld;
   logic       bypass;
   logic       flush;
   logic [7:0] dout [8];
   logic [7:0] dovld;
   logic       busy;

   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t q [8][$];

   relu_maxpool8 #(.POOL_K(2), .CNT_W(3)) dut (
      .clk_cal(clk), .rst_n(rst_n),
      .Pool_Din1(din[0]), .Pool_Din2(din[1]), .Pool_Din3(din[2]), .Pool_Din4(din[3]),
      .Pool_Din5(din[4]), .Pool_Din6(din[5]), .Pool_Din7(din[6]), .Pool_Din8(din[7]),
      .Pool_Din_vld1(dvld[0]), .Pool_Din_vld2(dvld[1]), .Pool_Din_vld3(dvld[2]),
      .Pool_Din_vld4(dvld[3]), .Pool_Din_vld5(dvld[4]), .Pool_Din_vld6(dvld[5]),
      .Pool_Din_vld7(dvld[6]), .Pool_Din_vld8(dvld[7]),
      .pool_bypass(bypass), .pool_flush(flush),
      .Pool_Dout1(dout[0]), .Pool_Dout2(dout[1]), .Pool_Dout3(dout[2]), .Pool_Dout4(dout[3]),
      .Pool_Dout5(dout[4]), .Pool_Dout6(dout[5]), .Pool_Dout7(dout[6]), .Pool_Dout8(dout[7]),
      .Pool_Dout_vld1(dovld[0]), .Pool_Dout_vld2(dovld[1]), .Pool_Dout_vld3(dovld[2]),
      .Pool_Dout_vld4(dovld[3]), .Pool_Dout_vld5(dovld[4]), .Pool_Dout_vld6(dovld[5]),
      .Pool_Dout_vld7(dovld[6]), .Pool_Dout_vld8(dovld[7]),
      .pool_busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Inputs set now are sampled by the next rising edge.
   // Their result is visible while cyc == cyc+1.
   task automatic put(input int l, input int v);
      din[l]  = 8'(v);
      dvld[l] = 1'b1;
   endtask

   task automatic expect_out(input int l, input int v);
      exp_t e;
      e.val = v;
      e.cyc = cyc + 1;
      q[l].push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      dvld  = '0;
      flush = 1'b0;
   endtask

   // Monitor: every output pulse must match the head of its lane queue.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int l = 0; l < 8; l++) begin
            if (dovld[l]) begin
               if (q[l].size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected pulse lane%0d: got data %0d, expected no pulse (cycle %0d)",
                           l + 1, dout[l], cyc);
               end else begin
                  exp_t e;
                  e = q[l].pop_front();
                  check($sformatf("lane%0d data", l + 1), int'(dout[l]), e.val);
                  check($sformatf("lane%0d cycle", l + 1), cyc, e.cyc);
               end
            end
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      bypass = 1'b0;
      flush  = 1'b0;
      dvld   = '0;
      for (int l = 0; l < 8; l++) din[l] = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // A completed window, then a partial window, then reset in mid-window.
      put(0, 50); tick();
      put(0, 60); expect_out(0, 60); tick();
      put(0, 10); tick();
      check("busy partial", int'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset dout1", int'(dout[0]), 0);
      check("reset vld", int'(dovld), 0);
      check("reset busy", int'(busy), 0);
      rst_n = 1'b1;
      tick();

      // Basic window on lane1
      put(0, 10); tick();
      put(0, 37); expect_out(0, 37); tick();

      // Full-rate streaming on lane3
      put(2, 5);   tick();
      put(2, 9);   expect_out(2, 9);   tick();
      put(2, 200); tick();
      put(2, 4);   expect_out(2, 200); tick();
      put(2, 0);   tick();
      put(2, 0);   expect_out(2, 0);   tick();
      check("dout1 hold", int'(dout[0]), 37);

      // Gapped lane2 concurrently with misaligned lane8
      put(1, 7); put(7, 255); tick();
      put(7, 254); expect_out(7, 255); tick();
      tick();
      tick();
      put(1, 3); expect_out(1, 7); tick();

      // Bypass: partial window on lane5 discarded, stream passes through
      put(4, 99); tick();
      bypass = 1'b1;
      put(4, 1); expect_out(4, 1); tick();
      put(4, 2); expect_out(4, 2); tick();
      tick();
      put(4, 3); flush = 1'b1; expect_out(4, 3); tick();
      check("busy bypass", int'(busy), 0);
      bypass = 1'b0;
      put(4, 40); tick();
      put(4, 30); expect_out(4, 40); tick();

      // Flush: lane4 and lane7 partial, same-cycle samples, lane6 idle
      put(3, 90); put(6, 11); tick();
      check("busy before flush", int'(busy), 1);
      flush = 1'b1;
      put(3, 120); put(6, 5);
`ifdef MAXPOOL_PARTIAL_FLUSH_EN
      expect_out(3, 120);
      expect_out(6, 11);
`endif
      tick();
      check("busy after flush", int'(busy), 0);
      put(3, 1); tick();
      put(3, 2); expect_out(3, 2); tick();

      repeat (4) tick();
      for (int l = 0; l < 8; l++)
         check($sformatf("lane%0d leftover", l + 1), q[l].size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
